// File: rtl/lighthouse_pulse_timestamper.sv
// rtl/lighthouse_pulse_timestamper.sv - photodiode pulse timestamper with record FIFO and Avalon-MM readout
//
// Purpose:
//   Synchronizes NUM_SENSORS photodiode envelopes, timestamps each rising edge
//   against a free-running 32-bit counter and measures the pulse width at the
//   falling edge. Completed pulses become {id, rise_ts, width16} records that
//   wait in a per-channel pending register, are arbitrated round-robin into a
//   record FIFO and are drained by the host over a small Avalon-MM slave.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   sensor_signals  asynchronous photodiode envelopes, active high
//   avs_address     word address (0 head LO, 1 head HI + pop, 2 status, 3 drop count)
//   avs_read        read strobe, readdata valid the following cycle
//   avs_readdata    registered read data
//   avs_write       write strobe (address 3 clears the drop counter)
//   avs_writedata   write data (contents ignored)
//   irq             level interrupt, fill >= IRQ_THRESHOLD, registered
//
// Configuration:
//   LIGHTHOUSE_GLITCH_FILTER_EN  when defined, pulses narrower than MIN_WIDTH
//                                cycles are discarded without counting a drop.

module lighthouse_pulse_timestamper #(
    parameter int NUM_SENSORS   = 15,
    parameter int FIFO_DEPTH    = 64,
    parameter int MIN_WIDTH     = 8,
    parameter int IRQ_THRESHOLD = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SENSORS-1:0] sensor_signals,
    input  logic [1:0]             avs_address,
    input  logic                   avs_read,
    output logic [31:0]            avs_readdata,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    output logic                   irq
);

    localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int ID_W   = 5;
    localparam int REC_W  = 32 + ID_W + 16;
    localparam int SEL_W  = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

`ifdef LIGHTHOUSE_GLITCH_FILTER_EN
    localparam logic [31:0] MIN_WIDTH_W = 32'(MIN_WIDTH);
`else
    localparam int unused_min_width = MIN_WIDTH;
`endif

    typedef enum logic [1:0] {
        CH_WAIT_LOW = 2'd0,
        CH_ARMED    = 2'd1,
        CH_HIGH     = 2'd2
    } ch_state_e;

    // Timebase and synchronizer warm-up
    logic [31:0] ts_q, ts_d;
    logic [1:0]  warm_q, warm_d;
    logic        warm_done;

    // Input path: two sync stages plus the previous synced level for edge detect
    logic [NUM_SENSORS-1:0] sync1_q, sync1_d;
    logic [NUM_SENSORS-1:0] sync2_q, sync2_d;
    logic [NUM_SENSORS-1:0] level_q, level_d;

    // Channel state and pending records
    ch_state_e              ch_state_q   [NUM_SENSORS];
    ch_state_e              ch_state_d   [NUM_SENSORS];
    logic [31:0]            rise_ts_q    [NUM_SENSORS];
    logic [31:0]            rise_ts_d    [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] pend_valid_q, pend_valid_d;
    logic [31:0]            pend_ts_q    [NUM_SENSORS];
    logic [31:0]            pend_ts_d    [NUM_SENSORS];
    logic [15:0]            pend_width_q [NUM_SENSORS];
    logic [15:0]            pend_width_d [NUM_SENSORS];

    // Arbiter
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W:0]   arb_idx;
    logic [SEL_W-1:0] grant_sel;
    logic             grant_valid;
    logic             do_grant;

    // FIFO
    logic [REC_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] fill;
    logic [31:0]      fill_w;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             can_push;
    logic [REC_W-1:0] push_rec;
    logic [REC_W-1:0] head_rec;

    // Drop counter, bus and irq
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic [5:0]  drop_num;
    logic [32:0] drop_sum;
    logic        drop_clear;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;

    // Per-channel temporaries
    logic [31:0] width_raw;
    logic [15:0] width_sat;
    logic        keep;

    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    // ------------------------------------------------------------------
    // FIFO status and host pop
    // ------------------------------------------------------------------
    always_comb begin
        fill       = wr_ptr_q - rd_ptr_q;
        fill_w     = 32'(fill);
        fifo_empty = (fill == '0);
        fifo_full  = (fill_w == 32'(FIFO_DEPTH));
        pop        = avs_read && (avs_address == 2'd1) && !fifo_empty;
        // A full FIFO still accepts a record when the host pops in the same cycle.
        can_push   = !fifo_full || pop;
        head_rec   = fifo_mem_q[rd_ptr_q[ADDR_W-1:0]];
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: first pending channel at or after rr_ptr_q
    // ------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = '0;
        arb_idx     = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            arb_idx = {1'b0, rr_ptr_q} + (SEL_W + 1)'(i);
            if (arb_idx >= (SEL_W + 1)'(NUM_SENSORS)) begin
                arb_idx = arb_idx - (SEL_W + 1)'(NUM_SENSORS);
            end
            if (!grant_valid && pend_valid_q[arb_idx[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_sel   = arb_idx[SEL_W-1:0];
            end
        end
        do_grant = grant_valid && can_push;

        rr_ptr_d = rr_ptr_q;
        if (do_grant) begin
            rr_ptr_d = (grant_sel == SEL_W'(NUM_SENSORS - 1)) ? '0 : grant_sel + 1'b1;
        end

        push_rec = {ID_W'(grant_sel), pend_width_q[grant_sel], pend_ts_q[grant_sel]};
    end

    // ------------------------------------------------------------------
    // Timebase, synchronizers and channel FSMs
    // ------------------------------------------------------------------
    always_comb begin
        ts_d      = ts_q + 32'd1;
        warm_d    = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        // sync2 only reflects the pins after two edges out of reset; until then
        // its 0 reset value must not be taken as "pin low".
        warm_done = (warm_q == 2'd2);

        sync1_d = sensor_signals;
        sync2_d = sync1_q;
        level_d = sync2_q;

        ch_state_d   = ch_state_q;
        rise_ts_d    = rise_ts_q;
        pend_ts_d    = pend_ts_q;
        pend_width_d = pend_width_q;
        pend_valid_d = pend_valid_q;
        drop_num     = '0;
        width_raw    = '0;
        width_sat    = '0;
        keep         = 1'b0;

        for (int ch = 0; ch < NUM_SENSORS; ch++) begin
            // The granted slot is free again before a new record is considered.
            if (do_grant && (grant_sel == SEL_W'(ch))) begin
                pend_valid_d[ch] = 1'b0;
            end

            case (ch_state_q[ch])
                CH_WAIT_LOW: begin
                    if (warm_done && !sync2_q[ch]) begin
                        ch_state_d[ch] = CH_ARMED;
                    end
                end
                CH_ARMED: begin
                    if (sync2_q[ch] && !level_q[ch]) begin
                        ch_state_d[ch] = CH_HIGH;
                        rise_ts_d[ch]  = ts_q;
                    end
                end
                CH_HIGH: begin
                    if (!sync2_q[ch] && level_q[ch]) begin
                        ch_state_d[ch] = CH_ARMED;
                        width_raw      = ts_q - rise_ts_q[ch];
                        width_sat      = (|width_raw[31:16]) ? 16'hFFFF : width_raw[15:0];
`ifdef LIGHTHOUSE_GLITCH_FILTER_EN
                        keep           = (width_raw >= MIN_WIDTH_W);
`else
                        keep           = 1'b1;
`endif
                        if (keep) begin
                            if (pend_valid_d[ch]) begin
                                drop_num = drop_num + 6'd1;
                            end else begin
                                pend_valid_d[ch] = 1'b1;
                                pend_ts_d[ch]    = rise_ts_q[ch];
                                pend_width_d[ch] = width_sat;
                            end
                        end
                    end
                end
                default: ch_state_d[ch] = CH_WAIT_LOW;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, drop counter, bus read mux, irq
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_grant);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        drop_clear = avs_write && (avs_address == 2'd3);
        drop_sum   = {1'b0, drop_cnt_q} + 33'(drop_num);
        if (drop_clear) begin
            drop_cnt_d = 32'(drop_num);
        end else if (drop_sum[32]) begin
            drop_cnt_d = 32'hFFFF_FFFF;
        end else begin
            drop_cnt_d = drop_sum[31:0];
        end

        readdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                2'd0:    readdata_d = fifo_empty ? 32'd0 : head_rec[31:0];
                2'd1:    readdata_d = fifo_empty ? 32'd0 : {11'd0, head_rec[REC_W-1:32]};
                2'd2:    readdata_d = {14'd0, fifo_full, fifo_empty, fill_w[15:0]};
                default: readdata_d = drop_cnt_q;
            endcase
        end

        irq_d = (fill_w >= 32'(IRQ_THRESHOLD));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q         <= '0;
            warm_q       <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            pend_valid_q <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            drop_cnt_q   <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
            for (int ch = 0; ch < NUM_SENSORS; ch++) begin
                ch_state_q[ch]   <= CH_WAIT_LOW;
                rise_ts_q[ch]    <= '0;
                pend_ts_q[ch]    <= '0;
                pend_width_q[ch] <= '0;
            end
        end else begin
            ts_q         <= ts_d;
            warm_q       <= warm_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            pend_valid_q <= pend_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
            for (int ch = 0; ch < NUM_SENSORS; ch++) begin
                ch_state_q[ch]   <= ch_state_d[ch];
                rise_ts_q[ch]    <= rise_ts_d[ch];
                pend_ts_q[ch]    <= pend_ts_d[ch];
                pend_width_q[ch] <= pend_width_d[ch];
            end
        end
    end

    // Record storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_grant) begin
            fifo_mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_rec;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_lighthouse_pulse_timestamper.sv
// tb/tb_lighthouse_pulse_timestamper.sv - scoreboard bench for lighthouse_pulse_timestamper

module tb_lighthouse_pulse_timestamper;

    localparam int N     = 15;
    localparam int DEPTH = 64;
    localparam int TH    = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  sensor_signals = '0;
    logic [1:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          irq;

    lighthouse_pulse_timestamper #(
        .NUM_SENSORS(N), .FIFO_DEPTH(DEPTH), .MIN_WIDTH(8), .IRQ_THRESHOLD(TH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sensor_signals(sensor_signals),
        .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    // Edges since reset release; equals the design's timestamp in that cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Scoreboard of expected read responses, and the reference record queue
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] rec_lo_q[$];
    logic [31:0] rec_hi_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: readdata is valid the cycle after a read strobe
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= avs_read && reset_n;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", avs_readdata, 32'hDEAD_BEEF ^ avs_readdata ^ 32'h1);
            end else begin
                check(name_q.pop_front(), avs_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        avs_read    = 1'b1;
        avs_address = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_write     = 1'b1;
        avs_address   = a;
        avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    // Reference: a pulse seen by the 2-FF synchronizer is stamped 2 cycles after
    // the pin moves; width is pin-high duration, saturated to 16 bits.
    task automatic expect_record(input int ch, input int unsigned rise_ts, input int unsigned width);
        logic [15:0] w16;
        logic [4:0]  id5;
`ifdef LIGHTHOUSE_GLITCH_FILTER_EN
        if (width < 8) return;
`endif
        w16 = (width > 65535) ? 16'hFFFF : width[15:0];
        id5 = ch[4:0];
        rec_lo_q.push_back(rise_ts);
        rec_hi_q.push_back({11'd0, id5, w16});
    endtask

    task automatic pulse(input int ch, input int unsigned width, input bit record);
        int unsigned r;
        sensor_signals[ch] = 1'b1;
        r = cyc;
        repeat (width) @(negedge clk);
        sensor_signals[ch] = 1'b0;
        if (record) expect_record(ch, r + 2, width);
    endtask

    task automatic drain();
        int   sz;
        logic exp_irq;
        while (rec_lo_q.size() > 0) begin
            rd(2'd0, rec_lo_q[0], "head_lo");
            rd(2'd1, rec_hi_q[0], "head_hi");
            void'(rec_lo_q.pop_front());
            void'(rec_hi_q.pop_front());
            idle(1);
            sz = rec_lo_q.size();
            if (sz > DEPTH) sz = DEPTH;
            exp_irq = (sz >= TH);
            check("irq_level", {31'd0, irq}, {31'd0, exp_irq});
        end
        rd(2'd2, 32'h0001_0000, "status_drained");
    endtask

    task automatic rand_batch();
        int chs[N];
        int fall_o[8];
        int wid[8];
        int nb, j, tmp, tmax;
        int unsigned s;
        for (int i = 0; i < N; i++) chs[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = chs[i]; chs[i] = chs[j]; chs[j] = tmp;
        end
        nb = $urandom_range(1, 8);
        for (int k = 0; k < nb; k++) begin
            fall_o[k] = 10 + 4 * k + $urandom_range(0, 2);
            wid[k]    = $urandom_range(1, fall_o[k] - 2);
        end
        tmax = fall_o[nb - 1];
        s = cyc;
        for (int c = 0; c <= tmax; c++) begin
            for (int k = 0; k < nb; k++) begin
                if (c == fall_o[k] - wid[k]) sensor_signals[chs[k]] = 1'b1;
                if (c == fall_o[k])          sensor_signals[chs[k]] = 1'b0;
            end
            @(negedge clk);
        end
        for (int k = 0; k < nb; k++) begin
            expect_record(chs[k], s + fall_o[k] - wid[k] + 2, wid[k]);
        end
        idle(10);
        drain();
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int unsigned r;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        check("irq_reset", {31'd0, irq}, 32'd0);
        check("readdata_reset", avs_readdata, 32'd0);
        rd(2'd2, 32'h0001_0000, "status_reset");
        rd(2'd3, 32'd0, "drop_reset");
        rd(2'd0, 32'd0, "empty_lo");
        rd(2'd1, 32'd0, "empty_hi");
        rd(2'd2, 32'h0001_0000, "status_after_empty_reads");
        idle(5);

        // Simultaneous falls on ch0 and ch14 with the pointer at 0
        sensor_signals[0]  = 1'b1;
        sensor_signals[14] = 1'b1;
        r = cyc;
        idle(30);
        sensor_signals[0]  = 1'b0;
        sensor_signals[14] = 1'b0;
        expect_record(0, r + 2, 30);
        expect_record(14, r + 2, 30);
        idle(10);
        rd(2'd3, 32'd0, "drop_simultaneous");
        drain();

        // ch3 high for 100 cycles
        pulse(3, 100, 1'b1);
        idle(10);
        rd(2'd2, 32'h0000_0001, "status_fill1");
        drain();

        // 3-cycle glitch on ch2
        pulse(2, 3, 1'b1);
        idle(10);
        rd(2'd3, 32'd0, "drop_glitch");
        drain();

        // Randomized overlapping pulses
        for (int b = 0; b < 20; b++) rand_batch();

        // Fill the FIFO, hold one pending, then drop one
        for (int p = 0; p < 65; p++) begin
            pulse(1, 10, 1'b1);
            idle(3);
        end
        idle(10);
        rd(2'd2, 32'h0002_0040, "status_full");
        check("irq_full", {31'd0, irq}, 32'd1);
        pulse(1, 10, 1'b0);
        idle(10);
        rd(2'd3, 32'd1, "drop_one");
        wr(2'd3, 32'h1234_5678);
        rd(2'd3, 32'd0, "drop_cleared");
        rd(2'd2, 32'h0002_0040, "status_still_full");
        drain();

        // Width saturation
        pulse(5, 70000, 1'b1);
        idle(10);
        drain();

        // ch7 high across reset release must not be recorded
        sensor_signals[7] = 1'b1;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(50);
        sensor_signals[7] = 1'b0;
        idle(10);
        pulse(7, 20, 1'b1);
        idle(10);
        rd(2'd2, 32'h0000_0001, "status_one_after_reset");
        drain();

        rd(2'd0, 32'd0, "final_empty_lo");
        rd(2'd1, 32'd0, "final_empty_hi");
        rd(2'd2, 32'h0001_0000, "final_status");
        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
